// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC prefix, LSB-first serialization,
// bit stuffing, NRZI line coding and EOP, driving D+/D- directly.
module usb_tx_encoder #(
  parameter int unsigned BIT_PERIOD  = 8,
  parameter int unsigned STUFF_LIMIT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  input  logic       tx_last,
  output logic       get_tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic       d_plus,
  output logic       d_minus
);

  localparam int unsigned TW = $clog2(BIT_PERIOD);
  localparam int unsigned OW = $clog2(STUFF_LIMIT + 1);

  typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [OW-1:0] ones;
  logic [7:0]    shreg;
  logic          last_byte;
  logic          in_data;
  logic          eop_cnt;

  logic bit_end, stuff_due, byte_end, bit_phase, next_bit, finish_pkt;

  always_comb begin
    bit_end    = (timer == TW'(BIT_PERIOD - 1));
    stuff_due  = (ones == OW'(STUFF_LIMIT));
    byte_end   = (bit_idx == 3'd7);
    bit_phase  = (state == SYNC) || (state == DATA) || (state == STUFF);
    next_bit   = byte_end ? tx_data[0] : shreg[bit_idx + 3'd1];
    finish_pkt = byte_end && (last_byte || !tx_data_valid);
  end

  // Combinational so the pulse marks the very edge that consumes tx_data
  // and can never be high while tx_data_valid is low.
  assign get_tx_data = bit_phase && bit_end && !stuff_due && byte_end &&
                       !last_byte && tx_data_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      ones      <= '0;
      shreg     <= '0;
      last_byte <= 1'b0;
      in_data   <= 1'b0;
      eop_cnt   <= 1'b0;
      d_plus    <= 1'b1;
      d_minus   <= 1'b0;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (state != IDLE)
        timer <= bit_end ? '0 : timer + TW'(1);

      case (state)
        IDLE: begin
          if (tx_start) begin
            // First SYNC bit is a 0, so the line toggles J->K right away.
            state     <= SYNC;
            timer     <= '0;
            tx_busy   <= 1'b1;
            shreg     <= 8'h80;
            bit_idx   <= '0;
            ones      <= '0;
            last_byte <= 1'b0;
            in_data   <= 1'b0;
            d_plus    <= 1'b0;
            d_minus   <= 1'b1;
          end
        end

        SYNC, DATA, STUFF: begin
          if (bit_end) begin
            if (stuff_due) begin
              state   <= STUFF;
              ones    <= '0;
              d_plus  <= ~d_plus;
              d_minus <= ~d_minus;
            end else if (finish_pkt) begin
              tx_error <= !last_byte;
              state    <= EOP_SE0;
              eop_cnt  <= 1'b0;
              d_plus   <= 1'b0;
              d_minus  <= 1'b0;
            end else begin
              if (next_bit) begin
                ones <= ones + OW'(1);
              end else begin
                ones    <= '0;
                d_plus  <= ~d_plus;
                d_minus <= ~d_minus;
              end
              bit_idx <= bit_idx + 3'd1;
              if (byte_end) begin
                shreg     <= tx_data;
                last_byte <= tx_last;
                in_data   <= 1'b1;
                state     <= DATA;
              end else begin
                state <= in_data ? DATA : SYNC;
              end
            end
          end
        end

        EOP_SE0: begin
          if (bit_end) begin
            if (eop_cnt) begin
              state   <= EOP_J;
              d_plus  <= 1'b1;
              d_minus <= 1'b0;
            end else begin
              eop_cnt <= 1'b1;
            end
          end
        end

        EOP_J: begin
          if (bit_end) begin
            state   <= IDLE;
            tx_done <= 1'b1;
            tx_busy <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
USB full-speed transmit path; the transmit counterpart of the receive bit timer/shift logic.
- Pulls bytes from the TX FIFO over a one-byte handshake and prepends the SYNC pattern.
- Serializes LSB-first at one bit per BIT_PERIOD clocks, applies bit stuffing and NRZI encoding, and appends EOP.
- Drives the D+/D- line outputs directly.

Parameters:
BIT_PERIOD, 8, clocks per USB bit time (>=4)
STUFF_LIMIT, 6, consecutive 1s after which a stuffed 0 is inserted

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
tx_start  input  1  one-cycle pulse; begin a packet; ignored while tx_busy=1
tx_data  input  8  next byte to send
tx_data_valid  input  1  tx_data holds a valid byte
tx_last  input  1  qualifies tx_data: byte is final byte of packet
get_tx_data  output  1  one-cycle pulse: tx_data/tx_last consumed this cycle
tx_busy  output  1  high from cycle after tx_start through final J bit
tx_done  output  1  one-cycle pulse on return to IDLE after EOP
tx_error  output  1  one-cycle pulse on underrun (no byte at byte boundary)
d_plus  output  1  registered D+ line
d_minus  output  1  registered D- line

Behaviour:
- Reset (async, rst=1): state IDLE; d_plus=1, d_minus=0 (J); all other outputs 0; all counters, stuff count and shift register cleared. Reset mid-packet aborts immediately, with no EOP.
- Line states: J = (1,0); K = (0,1); SE0 = (0,0). (1,1) is never driven.
- Bit timer: counts 0..BIT_PERIOD-1 while not IDLE. A bit boundary is timer==BIT_PERIOD-1; the line value for the next bit is registered there.
- NRZI: a 0 bit toggles J<->K; a 1 bit holds the line.
- FSM states: IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J.
- IDLE: drive J. On tx_start, go to SYNC next cycle with timer=0; the first SYNC bit appears on the lines in that same cycle (latency 1).
- SYNC: send 8'h80 LSB-first (bits 0,0,0,0,0,0,0,1), giving line K J K J K J K K.
- Byte boundary (end of last bit of SYNC or of a data byte, after any pending stuff bit), previous byte not last:
  - tx_data_valid=1: latch tx_data and tx_last, pulse get_tx_data for exactly that cycle, enter DATA seamlessly with no gap bit.
  - tx_data_valid=0: pulse tx_error, go to EOP_SE0.
- Last byte: at its boundary (tx_last latched=1), go to EOP_SE0.
- Stuffing:
  - Counter of consecutive transmitted 1s. It spans SYNC and byte boundaries; SYNC's final 1 counts.
  - When it reaches STUFF_LIMIT, the next bit slot is STUFF: a 0 (line toggle), counter reset to 0.
  - A stuffed bit delays the remaining data bits and the byte boundary by one bit time.
  - A stuff owed after the last data bit is sent before EOP.
  - Any 0 data bit resets the counter.
- EOP_SE0: SE0 for 2 bit times. EOP_J: J for 1 bit time.
  - At end of EOP_J: go to IDLE, pulse tx_done, tx_busy falls the same cycle.
- tx_start while busy: ignored, no effect.
- get_tx_data is never asserted unless tx_data_valid=1.
- tx_error and tx_done may both pulse in the same packet (underrun packet still ends with tx_done).

Test Plan:
1. Assert rst mid-operation -> d_plus=1, d_minus=0, tx_busy=0, get_tx_data=0 asynchronously; held until rst deasserted.
2. tx_start, tx_data=8'hA5, tx_last=1, valid=1 -> per 8-clock bit:
   - lines K J K J K J K K (SYNC), then K J J K J J K K (data), SE0 SE0, J;
   - get_tx_data pulse at clock 64 after start;
   - tx_done at clock 152.
3. Single byte 8'hFF, last -> stuffed 0 after 5th data bit (SYNC 1 + five 1s = 6):
   - data line sequence K K K K K J J J J;
   - EOP begins after 17 bit times;
   - tx_done at clock 160.
4. Two bytes 8'h3C then 8'hC3 (last), valid held high -> get_tx_data pulses exactly twice, 64 clocks apart; no idle bit between bytes; correct NRZI across the boundary.
5. Underrun: first byte 8'h00 not last, valid drops before its boundary -> tx_error pulse at boundary, then SE0 2 bits, J 1 bit, tx_done; no second get_tx_data.
6. tx_start pulsed again during DATA -> ignored; packet output identical to scenario 2.
